keypad_code_entry: RTL
======================

// Module: keypad_code_entry
// PURPOSE
//  Initiator side of the digital-lock handshake. Collects keypad digits, assembles a
//  DIGITS-digit code, presents it with a one-cycle start pulse to the lock controller,
//  then waits for done and latches the unlock/alarm verdict. Sits between the keypad
//  scanner and the lock control/datapath pair.
// PARAMETERS
//  DIGITS   4     digits per code; code_out width = 4*DIGITS
//  TIMEOUT  1000  idle cycles between keys before the partial entry is discarded (>=2)
//  TO_W     10    timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk          in   1         rising-edge clock; the only clock
//  rst_n        in   1         reset, synchronous, active-low
//  key_valid    in   1         key event is valid this cycle
//  key_code     in   4         0-9 digit; 4'hA clear; 4'hB enter; 4'hC-F ignored
//  key_ready    out  1         block accepts a key this cycle (IDLE or COLLECT)
//  code_out     out  4*DIGITS  assembled code; first digit in the MS nibble
//  start        out  1         one-cycle request pulse to the lock
//  lock_done    in   1         lock finished evaluating; level, sampled only in WAIT
//  lock_unlock  in   1         verdict: code accepted (valid with lock_done)
//  lock_alarm   in   1         verdict: attempts exhausted (valid with lock_done)
//  digit_cnt    out  3         digits held so far, 0..DIGITS
//  short_err    out  1         one-cycle pulse: enter pressed with digit_cnt<DIGITS
//  unlocked     out  1         sticky, set by an accepted code
//  lockout      out  1         sticky, set by an alarm; blocks all further entry
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge, any state, including mid-WAIT): state=IDLE,
//   code_out=0, digit_cnt=0, all 1-bit outputs 0 except key_ready=1, timer=0.
//  A key is accepted only when key_valid && key_ready. Keys are never queued.
//  States and transitions:
//  - IDLE: digit -> shift in, cnt=1, go COLLECT. clear/enter/C-F -> no effect.
//  - COLLECT: digit with cnt<DIGITS -> code_out = {code_out[4*DIGITS-5:0],digit},
//    cnt++. digit with cnt==DIGITS -> ignored (no shift, no cnt change).
//    clear -> code_out=0, cnt=0, go IDLE. enter with cnt<DIGITS -> short_err pulse
//    next cycle, code_out=0, cnt=0, go IDLE. enter with cnt==DIGITS -> go SUBMIT.
//  - SUBMIT: start=1 for exactly this one cycle. key_ready=0. Next state is WAIT.
//  - WAIT: key_ready=0; code_out held stable. On lock_done: lock_alarm -> lockout=1,
//    go LOCKED. Else lock_unlock -> unlocked=1, go IDLE. Else (reject) go IDLE.
//    On every exit to IDLE: code_out=0, cnt=0. Both verdicts set: alarm wins.
//  - LOCKED: absorbing state; key_ready=0; only rst_n leaves it.
//  Latency: enter accepted at edge N -> start high in cycle N+1 -> WAIT from N+2.
//  key_ready is combinational from state and is high only in IDLE and COLLECT.
//  unlocked is cleared by the next accepted digit; it is not cleared by a reject.
//  Timeout (see CONFIGURATION): the timer counts COLLECT cycles with no accepted key
//   and resets to 0 on every accepted key. At timer==TIMEOUT-1: code_out=0, cnt=0,
//   go IDLE. If a key is accepted in the same cycle, the key wins and the timer resets.
// CONFIGURATION
//  ENTRY_TIMEOUT_EN defined: the inter-key timeout above is active.
//  ENTRY_TIMEOUT_EN undefined: no timer logic is built; COLLECT waits indefinitely.
//   TIMEOUT and TO_W are unused.
// TESTING
//  1 Reset, keys 1,2,3,4,enter; lock_done+unlock 3 cycles after start ->
//    code_out=16'h1234 during WAIT, start high 1 cycle, unlocked=1, state IDLE.
//  2 Keys 5,6,enter -> short_err pulses once, start stays 0, digit_cnt=0.
//  3 Keys 1,2,3,4,9,enter -> the 9 is ignored, code_out=16'h1234, start pulses.
//  4 Key 7 then clear -> code_out=0, digit_cnt=0; a following enter has no effect.
//  5 Submit, lock_done+lock_alarm -> lockout=1, key_ready=0, keys ignored; after
//    rst_n low for 1 cycle: lockout=0, key_ready=1.
//  6 ENTRY_TIMEOUT_EN, TIMEOUT=8: key 3 then 8 idle cycles -> cnt=0, IDLE. Key on
//    the 8th idle cycle -> cnt=2 (key wins). Macro undefined -> cnt stays 1.

Source files
------------

// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects DIGITS key digits, submits the code to the lock with a start
// pulse and latches the verdict. Define ENTRY_TIMEOUT_EN to build the inter-key timeout.
module keypad_code_entry #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TO_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic                  key_ready,
  output logic [4*DIGITS-1:0]   code_out,
  output logic                  start,
  input  logic                  lock_done,
  input  logic                  lock_unlock,
  input  logic                  lock_alarm,
  output logic [2:0]            digit_cnt,
  output logic                  short_err,
  output logic                  unlocked,
  output logic                  lockout
);

  localparam int unsigned CodeW = 4 * DIGITS;

  if ((DIGITS < 1) || (DIGITS > 7) || (TIMEOUT < 2) || ((64'd1 << TO_W) <= 64'(TIMEOUT)))
  begin : g_bad_cfg
    $error("keypad_code_entry: illegal DIGITS/TIMEOUT/TO_W combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StSubmit,
    StWait,
    StLocked
  } state_e;

  state_e             state_q;
  logic [CodeW-1:0]   code_q;
  logic [2:0]         cnt_q;
  logic               start_q;
  logic               short_err_q;
  logic               unlocked_q;
  logic               lockout_q;

  logic               key_acc;
  logic               is_digit;
  logic               is_clear;
  logic               is_enter;
  logic               cnt_full;
  logic               timeout_hit;

  assign key_ready = (state_q == StIdle) || (state_q == StCollect);
  assign key_acc   = key_valid && key_ready;
  assign is_digit  = (key_code <= 4'd9);
  assign is_clear  = (key_code == 4'hA);
  assign is_enter  = (key_code == 4'hB);
  assign cnt_full  = (cnt_q == 3'(DIGITS));

`ifdef ENTRY_TIMEOUT_EN
  logic [TO_W-1:0] timer_q;
  // An accepted key in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q == StCollect) && !key_acc &&
                       (timer_q == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      code_q      <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      short_err_q <= 1'b0;
      unlocked_q  <= 1'b0;
      lockout_q   <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      start_q     <= 1'b0;
      short_err_q <= 1'b0;
      if (key_acc && is_digit) begin
        unlocked_q <= 1'b0;
      end
`ifdef ENTRY_TIMEOUT_EN
      if ((state_q == StCollect) && !key_acc && !timeout_hit) begin
        timer_q <= timer_q + 1'b1;
      end else begin
        timer_q <= '0;
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (key_acc && is_digit) begin
            code_q  <= CodeW'(key_code);
            cnt_q   <= 3'd1;
            state_q <= StCollect;
          end
        end
        StCollect: begin
          if (key_acc) begin
            if (is_digit) begin
              if (!cnt_full) begin
                code_q <= (code_q << 4) | CodeW'(key_code);
                cnt_q  <= cnt_q + 3'd1;
              end
            end else if (is_clear) begin
              code_q  <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end else if (is_enter) begin
              if (cnt_full) begin
                start_q <= 1'b1;
                state_q <= StSubmit;
              end else begin
                short_err_q <= 1'b1;
                code_q      <= '0;
                cnt_q       <= '0;
                state_q     <= StIdle;
              end
            end
          end else if (timeout_hit) begin
            code_q  <= '0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StSubmit: begin
          state_q <= StWait;
        end
        StWait: begin
          if (lock_done) begin
            if (lock_alarm) begin
              lockout_q <= 1'b1;
              state_q   <= StLocked;
            end else begin
              if (lock_unlock) begin
                unlocked_q <= 1'b1;
              end
              code_q  <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
            end
          end
        end
        StLocked: begin
          state_q <= StLocked;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign code_out  = code_q;
  assign digit_cnt = cnt_q;
  assign start     = start_q;
  assign short_err = short_err_q;
  assign unlocked  = unlocked_q;
  assign lockout   = lockout_q;

endmodule
